// File: rtl/rvfi_retire_buffer.sv
// In-order RVFI retire buffer fed by out-of-order writeback ports.
// Define RVFI_ORDER_EN to build the 64-bit rvfi_order counter.
module rvfi_retire_buffer #(
    parameter int DEPTH  = 8,
    parameter int XLEN   = 32,
    parameter int NUM_WB = 2,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    output logic [TW-1:0]                  issue_tag,
    input  logic [31:0]                    issue_insn,
    input  logic [XLEN-1:0]                issue_pc,
    input  logic [XLEN-1:0]                issue_next_pc,
    input  logic [4:0]                     issue_rs1_addr,
    input  logic [4:0]                     issue_rs2_addr,
    input  logic [4:0]                     issue_rs3_addr,
    input  logic [XLEN-1:0]                issue_rs1_rdata,
    input  logic [XLEN-1:0]                issue_rs2_rdata,
    input  logic [XLEN-1:0]                issue_rs3_rdata,
    input  logic [4:0]                     issue_rd_addr,
    input  logic                           issue_no_wb,
    input  logic                           stalled,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB-1:0][TW-1:0]      wb_tag,
    input  logic [NUM_WB-1:0][XLEN-1:0]    wb_data,
    input  logic                           flush_valid,
    input  logic [TW-1:0]                  flush_tag,
    output logic                           rvfi_valid,
    output logic [63:0]                    rvfi_order,
    output logic [31:0]                    rvfi_insn,
    output logic [4:0]                     rvfi_rs1_addr,
    output logic [4:0]                     rvfi_rs2_addr,
    output logic [4:0]                     rvfi_rs3_addr,
    output logic [XLEN-1:0]                rvfi_rs1_rdata,
    output logic [XLEN-1:0]                rvfi_rs2_rdata,
    output logic [XLEN-1:0]                rvfi_rs3_rdata,
    output logic [4:0]                     rvfi_rd_addr,
    output logic [XLEN-1:0]                rvfi_rd_wdata,
    output logic [XLEN-1:0]                rvfi_pc_rdata,
    output logic [XLEN-1:0]                rvfi_pc_wdata,
    output logic [TW:0]                    count,
    output logic                           wb_err
);

    logic [DEPTH-1:0] valid, done, pending, drop, wb_hit;
    logic [TW-1:0]    head, tail, flush_off;
    logic [TW-1:0]    age    [DEPTH];
    logic [XLEN-1:0]  wb_val [DEPTH];
    logic [31:0]      e_insn [DEPTH];
    logic [XLEN-1:0]  e_pc   [DEPTH];
    logic [XLEN-1:0]  e_npc  [DEPTH];
    logic [XLEN-1:0]  e_r1   [DEPTH];
    logic [XLEN-1:0]  e_r2   [DEPTH];
    logic [XLEN-1:0]  e_r3   [DEPTH];
    logic [XLEN-1:0]  e_wd   [DEPTH];
    logic [4:0]       e_a1   [DEPTH];
    logic [4:0]       e_a2   [DEPTH];
    logic [4:0]       e_a3   [DEPTH];
    logic [4:0]       e_rd   [DEPTH];
    logic             issue_fire, retire, wb_bad;
    logic [TW:0]      count_next;
    logic [63:0]      order_q;

    assign issue_ready = count < (TW+1)'(DEPTH);
    assign issue_tag   = tail;
    assign issue_fire  = issue_valid & issue_ready & ~stalled & ~flush_valid;
    assign retire      = valid[head] & done[head];
    assign pending     = valid & ~done;
    assign flush_off   = flush_tag - head;

    // Age relative to head orders entries from oldest to youngest.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age[i]  = TW'(i) - head;
            drop[i] = flush_valid & valid[i] & (age[i] > flush_off);
        end
    end

    always_comb begin
        wb_hit = '0;
        wb_bad = 1'b0;
        for (int i = 0; i < DEPTH; i++) wb_val[i] = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && !drop[wb_tag[k]]) begin
                if (pending[wb_tag[k]]) begin
                    wb_hit[wb_tag[k]] = 1'b1;
                    wb_val[wb_tag[k]] = wb_data[k];
                end else begin
                    wb_bad = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (flush_valid)
            count_next = {1'b0, flush_off} + (TW+1)'(1)
                       - {{TW{1'b0}}, retire};
        else
            count_next = count + {{TW{1'b0}}, issue_fire}
                       - {{TW{1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            valid  <= '0;
            done   <= '0;
            wb_err <= 1'b0;
        end else begin
            head  <= head + TW'(retire);
            tail  <= flush_valid ? flush_tag + TW'(1) : tail + TW'(issue_fire);
            count <= count_next;
            if (wb_bad) wb_err <= 1'b1;
            done  <= done | wb_hit;
            valid <= valid & ~drop;
            if (retire) valid[head] <= 1'b0;
            if (issue_fire) begin
                valid[tail] <= 1'b1;
                done[tail]  <= issue_no_wb;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (wb_hit[i]) e_wd[i] <= wb_val[i];
        if (issue_fire) begin
            e_insn[tail] <= issue_insn;
            e_pc[tail]   <= issue_pc;
            e_npc[tail]  <= issue_next_pc;
            e_a1[tail]   <= issue_rs1_addr;
            e_a2[tail]   <= issue_rs2_addr;
            e_a3[tail]   <= issue_rs3_addr;
            e_r1[tail]   <= issue_rs1_rdata;
            e_r2[tail]   <= issue_rs2_rdata;
            e_r3[tail]   <= issue_rs3_rdata;
            e_rd[tail]   <= issue_rd_addr;
            e_wd[tail]   <= '0;
        end
    end

`ifdef RVFI_ORDER_EN
    always_ff @(posedge clk) begin
        if (reset)       order_q <= '0;
        else if (retire) order_q <= order_q + 64'd1;
    end
`else
    assign order_q = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset || !retire) begin
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs3_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rs3_rdata <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
        end else begin
            rvfi_valid     <= 1'b1;
            rvfi_order     <= order_q;
            rvfi_insn      <= e_insn[head];
            rvfi_rs1_addr  <= e_a1[head];
            rvfi_rs2_addr  <= e_a2[head];
            rvfi_rs3_addr  <= e_a3[head];
            rvfi_rs1_rdata <= e_r1[head];
            rvfi_rs2_rdata <= e_r2[head];
            rvfi_rs3_rdata <= e_r3[head];
            rvfi_rd_addr   <= e_rd[head];
            rvfi_rd_wdata  <= (e_rd[head] == 5'd0) ? '0 : e_wd[head];
            rvfi_pc_rdata  <= e_pc[head];
            rvfi_pc_wdata  <= e_npc[head];
        end
    end

    a_flush_tag: assert property (@(posedge clk) disable iff (reset)
        flush_valid |-> valid[flush_tag]);

    for (genvar k = 0; k < NUM_WB; k++) begin : g_chk
        a_wb_issue: assert property (@(posedge clk) disable iff (reset)
            !(issue_fire && wb_valid[k] && wb_tag[k] == tail));
    end

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Randomized and directed bench for rvfi_retire_buffer.
// Expected values come from an issue-order queue model of the buffer.
module tb_rvfi_retire_buffer;
    localparam int DEPTH  = 8;
    localparam int XLEN   = 32;
    localparam int NUM_WB = 2;
    localparam int TW     = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;
    logic issue_valid, issue_ready, issue_no_wb, stalled;
    logic [TW-1:0] issue_tag;
    logic [31:0] issue_insn;
    logic [XLEN-1:0] issue_pc, issue_next_pc;
    logic [4:0] issue_rs1_addr, issue_rs2_addr, issue_rs3_addr, issue_rd_addr;
    logic [XLEN-1:0] issue_rs1_rdata, issue_rs2_rdata, issue_rs3_rdata;
    logic [NUM_WB-1:0] wb_valid;
    logic [NUM_WB-1:0][TW-1:0] wb_tag;
    logic [NUM_WB-1:0][XLEN-1:0] wb_data;
    logic flush_valid;
    logic [TW-1:0] flush_tag;
    logic rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [4:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic [XLEN-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
    logic [XLEN-1:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [TW:0] count;
    logic wb_err;

    always #5 clk = ~clk;

    rvfi_retire_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_tag(issue_tag), .issue_insn(issue_insn),
        .issue_pc(issue_pc), .issue_next_pc(issue_next_pc),
        .issue_rs1_addr(issue_rs1_addr), .issue_rs2_addr(issue_rs2_addr),
        .issue_rs3_addr(issue_rs3_addr),
        .issue_rs1_rdata(issue_rs1_rdata), .issue_rs2_rdata(issue_rs2_rdata),
        .issue_rs3_rdata(issue_rs3_rdata),
        .issue_rd_addr(issue_rd_addr), .issue_no_wb(issue_no_wb),
        .stalled(stalled),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs3_addr(rvfi_rs3_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rs3_rdata(rvfi_rs3_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .count(count), .wb_err(wb_err)
    );

    typedef struct {
        int tag;
        logic [31:0] insn;
        logic [XLEN-1:0] pc, npc, r1, r2, r3, wdata;
        logic [4:0] a1, a2, a3, rd;
        bit done;
    } ent_t;

    ent_t q[$];
    int m_tail;
    logic [63:0] m_order;
    bit m_err;

    logic x_valid, x_err, x_ready;
    logic [63:0] x_order;
    logic [31:0] x_insn;
    logic [4:0] x_a1, x_a2, x_a3, x_rd;
    logic [XLEN-1:0] x_r1, x_r2, x_r3, x_wd, x_pc, x_npc;
    logic [TW:0] x_count;
    logic [TW-1:0] x_tag;

    logic [XLEN-1:0] ret_pc[$], ret_wd[$];
    logic [63:0] ret_ord[$];

    int n_vec = 0;
    int n_err = 0;

    // Advance the queue model by one clock using the inputs now applied.
    task automatic model_step();
        int fi, idx;
        bit ret, fire, shadow;
        ent_t r;
        {x_valid, x_order, x_insn, x_a1, x_a2, x_a3} = '0;
        {x_r1, x_r2, x_r3, x_rd, x_wd, x_pc, x_npc} = '0;
        if (reset) begin
            q.delete();
            m_tail = 0;
            m_order = '0;
            m_err = 0;
        end else begin
            fire = issue_valid && q.size() < DEPTH && !stalled && !flush_valid;
            ret = q.size() > 0 && q[0].done;
            fi = q.size();
            if (flush_valid)
                foreach (q[i]) if (q[i].tag == int'(flush_tag)) fi = i;
            for (int k = 0; k < NUM_WB; k++) begin
                shadow = 0;
                idx = -1;
                for (int j = k + 1; j < NUM_WB; j++)
                    if (wb_valid[j] && wb_tag[j] == wb_tag[k]) shadow = 1;
                if (wb_valid[k] && !shadow) begin
                    foreach (q[i]) if (q[i].tag == int'(wb_tag[k])) idx = i;
                    if (idx >= 0 && flush_valid && idx > fi) begin
                        m_err = m_err;
                    end else if (idx >= 0 && !q[idx].done) begin
                        q[idx].done = 1;
                        q[idx].wdata = wb_data[k];
                    end else begin
                        m_err = 1;
                    end
                end
            end
            if (flush_valid) begin
                while (q.size() > fi + 1) void'(q.pop_back());
                m_tail = (int'(flush_tag) + 1) % DEPTH;
            end
            if (ret) begin
                r = q.pop_front();
                x_valid = 1;
                x_insn = r.insn;
                x_a1 = r.a1; x_a2 = r.a2; x_a3 = r.a3;
                x_r1 = r.r1; x_r2 = r.r2; x_r3 = r.r3;
                x_rd = r.rd;
                x_wd = (r.rd == 5'd0) ? '0 : r.wdata;
                x_pc = r.pc;
                x_npc = r.npc;
`ifdef RVFI_ORDER_EN
                x_order = m_order;
`endif
                m_order = m_order + 64'd1;
            end
            if (fire) begin
                r.tag = m_tail;
                r.insn = issue_insn;
                r.pc = issue_pc; r.npc = issue_next_pc;
                r.a1 = issue_rs1_addr; r.a2 = issue_rs2_addr;
                r.a3 = issue_rs3_addr;
                r.r1 = issue_rs1_rdata; r.r2 = issue_rs2_rdata;
                r.r3 = issue_rs3_rdata;
                r.rd = issue_rd_addr;
                r.done = issue_no_wb;
                r.wdata = '0;
                q.push_back(r);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        x_count = (TW+1)'(q.size());
        x_err = m_err;
        x_ready = q.size() < DEPTH;
        x_tag = TW'(m_tail);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        if (rvfi_valid) begin
            ret_pc.push_back(rvfi_pc_rdata);
            ret_wd.push_back(rvfi_rd_wdata);
            ret_ord.push_back(rvfi_order);
        end
    endtask

    task automatic idle();
        reset = 0;
        issue_valid = 0;
        issue_no_wb = 0;
        stalled = 0;
        wb_valid = '0;
        wb_tag = '0;
        wb_data = '0;
        flush_valid = 0;
        flush_tag = '0;
    endtask

    task automatic put_issue(input logic [XLEN-1:0] pc, input bit nowb,
                             input logic [4:0] rd);
        issue_valid = 1;
        issue_pc = pc;
        issue_next_pc = pc + 4;
        issue_no_wb = nowb;
        issue_rd_addr = rd;
        issue_insn = $urandom;
        issue_rs1_addr = 5'($urandom);
        issue_rs2_addr = 5'($urandom);
        issue_rs3_addr = 5'($urandom);
        issue_rs1_rdata = $urandom;
        issue_rs2_rdata = $urandom;
        issue_rs3_rdata = $urandom;
    endtask

    task automatic put_wb(input int k, input int tag, input logic [XLEN-1:0] d);
        wb_valid[k] = 1'b1;
        wb_tag[k] = TW'(tag);
        wb_data[k] = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
        ret_pc.delete();
        ret_wd.delete();
        ret_ord.delete();
    endtask

    task automatic test_reset();
        issue_insn = '0; issue_pc = '0; issue_next_pc = '0;
        issue_rs1_addr = '0; issue_rs2_addr = '0; issue_rs3_addr = '0;
        issue_rs1_rdata = '0; issue_rs2_rdata = '0; issue_rs3_rdata = '0;
        issue_rd_addr = '0;
        do_reset();
        n_vec++;
        if ({rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_rd_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_rvfi got v=%b ord=%0d pc=%h wd=%h want 0",
                     rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_rd_wdata);
        end
        n_vec++;
        if ({count, wb_err, issue_ready, issue_tag} !== {4'd0, 1'b0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL reset_ctrl got cnt=%0d err=%b rdy=%b tag=%0d want 0/0/1/0",
                     count, wb_err, issue_ready, issue_tag);
        end
    endtask

    task automatic test_in_order();
        logic [XLEN-1:0] epc [3];
        logic [XLEN-1:0] ewd [3];
        logic [63:0] eord [3];
        epc = '{32'h0, 32'h4, 32'h8};
        ewd = '{32'h0, 32'h44, 32'h88};
`ifdef RVFI_ORDER_EN
        eord = '{64'd0, 64'd1, 64'd2};
`else
        eord = '{64'd0, 64'd0, 64'd0};
`endif
        do_reset();
        put_issue(32'h0, 1, 5'd1); step();
        put_issue(32'h4, 0, 5'd2); step();
        put_issue(32'h8, 0, 5'd3); put_wb(0, 1, 32'h44); step();
        idle(); put_wb(0, 2, 32'h88); step();
        idle(); step(); step(); step();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= ret_pc.size() || ret_pc[i] !== epc[i] || ret_wd[i] !== ewd[i]
                || ret_ord[i] !== eord[i]) begin
                n_err++;
                $display("FAIL in_order retire %0d got n=%0d want pc=%h wd=%h ord=%0d",
                         i, ret_pc.size(), epc[i], ewd[i], eord[i]);
            end
        end
        n_vec++;
        if (count !== 4'd0 || ret_pc.size() != 3) begin
            n_err++;
            $display("FAIL in_order_drain got cnt=%0d n=%0d want 0/3", count, ret_pc.size());
        end
    endtask

    task automatic test_out_of_order();
        logic [XLEN-1:0] ewd [3];
        ewd = '{32'hA, 32'hB, 32'hC};
        do_reset();
        put_issue(32'h100, 0, 5'd5); step();
        put_issue(32'h104, 0, 5'd6); step();
        put_issue(32'h108, 0, 5'd7); step();
        idle(); put_wb(0, 2, 32'hC); step();
        idle(); step(); step();
        put_wb(0, 0, 32'hA); step();
        n_vec++;
        if (ret_pc.size() != 0) begin
            n_err++;
            $display("FAIL ooo_early got %0d retires want 0", ret_pc.size());
        end
        idle(); put_wb(1, 1, 32'hB); step();
        idle(); step(); step(); step();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= ret_pc.size() || ret_pc[i] !== 32'h100 + 32'(4 * i)
                || ret_wd[i] !== ewd[i]) begin
                n_err++;
                $display("FAIL ooo_retire %0d got n=%0d want wd=%h", i, ret_pc.size(), ewd[i]);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            put_issue(32'h1000 + 32'(4 * i), 0, 5'(i + 1));
            step();
        end
        idle();
        n_vec++;
        if ({issue_ready, count, issue_tag} !== {1'b0, 4'd8, 3'd0}) begin
            n_err++;
            $display("FAIL full got rdy=%b cnt=%0d tag=%0d want 0/8/0",
                     issue_ready, count, issue_tag);
        end
        put_issue(32'h2000, 0, 5'd9); step(); idle();
        n_vec++;
        if (count !== 4'd8) begin
            n_err++;
            $display("FAIL full_ignore got cnt=%0d want 8", count);
        end
        put_wb(0, 0, 32'h77); step(); idle();
        n_vec++;
        if (count !== 4'd8 || issue_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_wb got cnt=%0d rdy=%b want 8/0", count, issue_ready);
        end
        step();
        n_vec++;
        if (count !== 4'd7 || issue_ready !== 1'b1 || ret_pc.size() != 1
            || issue_tag !== 3'd0) begin
            n_err++;
            $display("FAIL full_retire got cnt=%0d rdy=%b n=%0d tag=%0d want 7/1/1/0",
                     count, issue_ready, ret_pc.size(), issue_tag);
        end
        put_issue(32'h3000, 1, 5'd0); step(); idle();
        n_vec++;
        if (count !== 4'd8 || issue_tag !== 3'd1) begin
            n_err++;
            $display("FAIL full_wrap got cnt=%0d tag=%0d want 8/1", count, issue_tag);
        end
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] epc [4];
        epc = '{32'h500, 32'h504, 32'h508, 32'h600};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            put_issue(32'h500 + 32'(4 * i), 0, 5'(i + 1));
            step();
        end
        idle();
        flush_valid = 1; flush_tag = 3'd2; put_wb(0, 4, 32'h99); step(); idle();
        n_vec++;
        if ({count, issue_tag, wb_err} !== {4'd3, 3'd3, 1'b0}) begin
            n_err++;
            $display("FAIL flush got cnt=%0d tag=%0d err=%b want 3/3/0",
                     count, issue_tag, wb_err);
        end
        put_issue(32'h600, 1, 5'd1); step(); idle();
        n_vec++;
        if (count !== 4'd4 || issue_tag !== 3'd4) begin
            n_err++;
            $display("FAIL flush_issue got cnt=%0d tag=%0d want 4/4", count, issue_tag);
        end
        put_wb(0, 0, 32'h1); put_wb(1, 1, 32'h2); step();
        idle(); put_wb(0, 2, 32'h3); step();
        idle();
        repeat (5) step();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= ret_pc.size() || ret_pc[i] !== epc[i]) begin
                n_err++;
                $display("FAIL flush_retire %0d got n=%0d want pc=%h", i, ret_pc.size(), epc[i]);
            end
        end
    endtask

    task automatic test_wb_err();
        do_reset();
        put_issue(32'h700, 0, 5'd4); step();
        idle(); put_wb(0, 0, 32'h1); put_wb(1, 0, 32'h2); step();
        idle();
        n_vec++;
        if (wb_err !== 1'b0) begin
            n_err++;
            $display("FAIL dual_wb_err got %b want 0", wb_err);
        end
        step();
        n_vec++;
        if (ret_wd.size() != 1 || ret_wd[0] !== 32'h2) begin
            n_err++;
            $display("FAIL dual_wb_data got n=%0d want wd=2", ret_wd.size());
        end
        put_issue(32'h704, 0, 5'd4); step();
        idle(); put_wb(1, 1, 32'h5); step();
        idle(); put_wb(0, 1, 32'h6); step();
        idle();
        n_vec++;
        if (wb_err !== 1'b1 || ret_wd.size() != 2 || ret_wd[1] !== 32'h5) begin
            n_err++;
            $display("FAIL done_wb got err=%b n=%0d want 1/2 wd=5", wb_err, ret_wd.size());
        end
        do_reset();
        n_vec++;
        if (wb_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear got %b want 0", wb_err);
        end
        put_wb(0, 5, 32'h55); step();
        idle(); step(); step();
        n_vec++;
        if (wb_err !== 1'b1 || ret_pc.size() != 0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL empty_wb got err=%b n=%0d cnt=%0d want 1/0/0",
                     wb_err, ret_pc.size(), count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put_issue(32'h800 + 32'(4 * i), 0, 5'(i + 1));
            step();
        end
        idle(); put_wb(0, 0, 32'h11); step();
        idle(); reset = 1; step(); reset = 0;
        n_vec++;
        if ({rvfi_valid, rvfi_pc_rdata, rvfi_rd_wdata, count, issue_tag, issue_ready}
            !== {1'b0, 32'h0, 32'h0, 4'd0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid got v=%b pc=%h cnt=%0d tag=%0d want 0/0/0/0",
                     rvfi_valid, rvfi_pc_rdata, count, issue_tag);
        end
        ret_pc.delete(); ret_wd.delete(); ret_ord.delete();
        put_issue(32'h900, 1, 5'd2); step();
        idle(); step();
        n_vec++;
        if (ret_pc.size() != 1 || ret_pc[0] !== 32'h900 || ret_ord[0] !== 64'd0) begin
            n_err++;
            $display("FAIL reset_restart got n=%0d want pc=900 ord=0", ret_pc.size());
        end
    endtask

    task automatic test_random();
        logic [317:0] obs, expv;
        int pend[$];
        int t, shown;
        bit fire;
        shown = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            idle();
            reset = ($urandom_range(0, 199) == 0);
            stalled = ($urandom_range(0, 9) == 0);
            if (q.size() > 0 && $urandom_range(0, 29) == 0) begin
                flush_valid = 1;
                flush_tag = TW'(q[$urandom_range(0, q.size() - 1)].tag);
            end
            if ($urandom_range(0, 9) < 6)
                put_issue(32'($urandom), $urandom_range(0, 2) == 0,
                          5'($urandom_range(0, 7)));
            fire = issue_valid && q.size() < DEPTH && !stalled && !flush_valid;
            pend.delete();
            foreach (q[i]) if (!q[i].done) pend.push_back(q[i].tag);
            for (int k = 0; k < NUM_WB; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (pend.size() > 0 && $urandom_range(0, 15) != 0)
                        t = pend[$urandom_range(0, pend.size() - 1)];
                    else
                        t = $urandom_range(0, DEPTH - 1);
                    if (!(fire && t == m_tail)) put_wb(k, t, $urandom);
                end
            end
            step();
            obs = {rvfi_valid, rvfi_order, rvfi_insn, rvfi_rs1_addr, rvfi_rs2_addr,
                   rvfi_rs3_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata,
                   rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
                   count, wb_err, issue_ready, issue_tag};
            expv = {x_valid, x_order, x_insn, x_a1, x_a2, x_a3, x_r1, x_r2, x_r3,
                    x_rd, x_wd, x_pc, x_npc, x_count, x_err, x_ready, x_tag};
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                if (shown < 10)
                    $display("FAIL random cyc %0d got %h want %h", c, obs, expv);
                shown++;
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_in_order();
        test_out_of_order();
        test_full();
        test_flush();
        test_wb_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
